// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and helpers for the pipeline stall controller.
// Holds the reset level, default depths and the watchdog limit in one place.
package pipe_stall_ctrl_pkg;

  localparam logic RST_ACTIVE = 1'b1;

  localparam int DEF_NSTAGE   = 6;
  localparam int DEF_NREQ     = 2;
  localparam int DEF_CNTW     = 5;
  localparam int DEF_MC_DEPTH = 3;
  localparam int DEF_TMOUT    = 255;

  localparam logic [7:0] DEF_REQ_DEPTH0 = 8'd1;
  localparam logic [7:0] DEF_REQ_DEPTH1 = 8'd3;

  // Masks are built at this width and narrowed to NSTAGE by the caller.
  localparam int MAX_NSTAGE = 32;

  // Freeze mask covering stages [depth:0]; depths past the last stage clamp to it.
  function automatic logic [MAX_NSTAGE-1:0] depth_mask(input int unsigned depth,
                                                       input int unsigned nstage);
    int unsigned           d;
    logic [MAX_NSTAGE-1:0] m;
    d = (depth >= nstage) ? nstage - 1 : depth;
    m = '0;
    for (int unsigned i = 0; i < MAX_NSTAGE; i++) m[i] = (i <= d);
    return m;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline and its stall controller.
interface pipe_stall_ctrl_if #(
  parameter int NSTAGE = 6,
  parameter int NREQ   = 2,
  parameter int CNTW   = 5
);
  logic [NREQ-1:0]   req;
  logic              mc_start;
  logic [CNTW-1:0]   mc_cycles;
  logic              flush;
  logic              stop_stall;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] bubble;
  logic              mc_busy;
  logic              stall_timeout;
  logic [31:0]       stall_cnt;

  modport master (
    output req, mc_start, mc_cycles, flush, stop_stall,
    input  stall, bubble, mc_busy, stall_timeout, stall_cnt
  );

  modport slave (
    input  req, mc_start, mc_cycles, flush, stop_stall,
    output stall, bubble, mc_busy, stall_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl_mc_counter.sv
// Multicycle stall down-counter: load, decrement to zero, clear, busy.
module stall_mc_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            clr,
  output logic            busy
);
  logic [CNTW-1:0] cnt_q, cnt_d;

  // A load is only taken from idle; a running count cannot be restarted.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                         cnt_d = '0;
    else if (load && cnt_q == '0)    cnt_d = load_val;
    else if (cnt_q != '0)            cnt_d = cnt_q - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) cnt_q <= '0;
    else                   cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Per-stage freeze/bubble generation from level requesters and a multicycle
// counter, with a continuous-stall watchdog and a saturating stall counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int                NSTAGE    = DEF_NSTAGE,
  parameter int                NREQ      = DEF_NREQ,
  parameter logic [NREQ*8-1:0] REQ_DEPTH = {DEF_REQ_DEPTH1, DEF_REQ_DEPTH0},
  parameter int                MC_DEPTH  = DEF_MC_DEPTH,
  parameter int                CNTW      = DEF_CNTW,
  parameter int                TMOUT     = DEF_TMOUT
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam int RUNW = (TMOUT < 2) ? 1 : $clog2(TMOUT + 1);
  localparam logic [NSTAGE-1:0] MC_MASK = NSTAGE'(depth_mask(32'(MC_DEPTH), 32'(NSTAGE)));

  logic [NREQ-1:0][NSTAGE-1:0] req_mask;
  logic [NSTAGE-1:0]           stall_raw, stall_v, bubble_v;
  logic                        mc_load, mc_busy, mc_act;

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_req
    localparam logic [NSTAGE-1:0] M = NSTAGE'(depth_mask(32'(REQ_DEPTH[gi*8 +: 8]), 32'(NSTAGE)));
    assign req_mask[gi] = bus.req[gi] ? M : '0;
  end

  // Flush wins over a same-cycle start; a zero-length start is a no-op.
  assign mc_load = bus.mc_start && (bus.mc_cycles != '0) && !bus.flush;
  assign mc_act  = mc_busy || (bus.mc_start && (bus.mc_cycles != '0));

  stall_mc_counter #(.CNTW(CNTW)) u_mc (
    .clk      (clk),
    .rst      (rst),
    .load     (mc_load),
    .load_val (bus.mc_cycles - CNTW'(1)),
    .clr      (bus.flush),
    .busy     (mc_busy)
  );

  always_comb begin
    stall_raw = mc_act ? MC_MASK : '0;
    for (int i = 0; i < NREQ; i++) stall_raw |= req_mask[i];
    stall_v = stall_raw;
    if (rst == RST_ACTIVE || bus.flush || bus.stop_stall) stall_v = '0;
    bubble_v = '0;
    for (int k = 1; k < NSTAGE; k++) bubble_v[k] = stall_v[k-1] & ~stall_v[k];
  end

  logic [RUNW-1:0] run_q, run_d;
  logic            tmo_q, tmo_d;
  logic [31:0]     scnt_q, scnt_d;

  // Run length tracks the fetch stage only; any unstalled cycle restarts it.
  always_comb begin
    run_d  = '0;
    tmo_d  = tmo_q;
    scnt_d = scnt_q;
    if (stall_v[0]) begin
      run_d = (run_q == RUNW'(TMOUT)) ? run_q : run_q + RUNW'(1);
      if (run_d == RUNW'(TMOUT)) tmo_d = 1'b1;
      if (scnt_q != '1) scnt_d = scnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      run_q  <= '0;
      tmo_q  <= 1'b0;
      scnt_q <= '0;
    end else begin
      run_q  <= run_d;
      tmo_q  <= tmo_d;
      scnt_q <= scnt_d;
    end
  end

  assign bus.stall         = stall_v;
  assign bus.bubble        = bubble_v;
  assign bus.mc_busy       = mc_busy;
  assign bus.stall_timeout = tmo_q;
  assign bus.stall_cnt     = scnt_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: expected masks are queued as each cycle
// is driven and compared once the combinational outputs settle.
module tb_pipe_stall_ctrl;
  typedef struct {
    string      tag;
    logic [5:0] stall;
    logic [5:0] bubble;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];

  pipe_stall_ctrl_if #(.NSTAGE(6), .NREQ(2), .CNTW(5)) bus ();

  pipe_stall_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the edge, queue the expectation, check mid-cycle.
  task automatic stp(input string tag, input logic rs, input logic [1:0] r,
                     input logic ms, input logic [4:0] mc, input logic fl, input logic ss,
                     input logic [5:0] e_st, input logic [5:0] e_bb, input logic e_busy);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = rs;
    bus.req        = r;
    bus.mc_start   = ms;
    bus.mc_cycles  = mc;
    bus.flush      = fl;
    bus.stop_stall = ss;
    e.tag = tag; e.stall = e_st; e.bubble = e_bb; e.busy = e_busy;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".stall"},   32'(bus.stall),   32'(e.stall));
    chk({e.tag, ".bubble"},  32'(bus.bubble),  32'(e.bubble));
    chk({e.tag, ".mc_busy"}, 32'(bus.mc_busy), 32'(e.busy));
  endtask

  initial begin
    bus.req = '0; bus.mc_start = 1'b0; bus.mc_cycles = '0;
    bus.flush = 1'b0; bus.stop_stall = 1'b0;

    // reset holds outputs low even with requests active
    stp("rst0", 1, 2'b11, 1, 5'd5, 0, 0, 6'b000000, 6'b000000, 0);
    stp("rst1", 1, 2'b11, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    chk("rst.stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst.timeout", 32'(bus.stall_timeout), 32'd0);

    // level requesters
    stp("idle",   0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    stp("req01",  0, 2'b01, 0, 5'd0, 0, 0, 6'b000011, 6'b000100, 0);
    stp("req10",  0, 2'b10, 0, 5'd0, 0, 0, 6'b001111, 6'b010000, 0);
    stp("req11",  0, 2'b11, 0, 5'd0, 0, 0, 6'b001111, 6'b010000, 0);
    stp("stop",   0, 2'b11, 0, 5'd0, 0, 1, 6'b000000, 6'b000000, 0);
    stp("flush",  0, 2'b11, 0, 5'd0, 1, 0, 6'b000000, 6'b000000, 0);
    stp("idle2",  0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    chk("cnt3.stall_cnt", bus.stall_cnt, 32'd3);

    // 3-cycle multicycle; restart attempt while busy is ignored
    stp("mc3.t0", 0, 2'b00, 1, 5'd3, 0, 0, 6'b001111, 6'b010000, 0);
    stp("mc3.t1", 0, 2'b00, 1, 5'd5, 0, 0, 6'b001111, 6'b010000, 1);
    stp("mc3.t2", 0, 2'b00, 0, 5'd0, 0, 0, 6'b001111, 6'b010000, 1);
    stp("mc3.t3", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    stp("mc3.t4", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);

    // zero-length and one-cycle starts
    stp("mc0.t0", 0, 2'b00, 1, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    stp("mc0.t1", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    stp("mc1.t0", 0, 2'b00, 1, 5'd1, 0, 0, 6'b001111, 6'b010000, 0);
    stp("mc1.t1", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);

    // counter keeps running underneath stop_stall
    stp("mcs.t0", 0, 2'b00, 1, 5'd4, 0, 0, 6'b001111, 6'b010000, 0);
    stp("mcs.t1", 0, 2'b00, 0, 5'd0, 0, 1, 6'b000000, 6'b000000, 1);
    stp("mcs.t2", 0, 2'b00, 0, 5'd0, 0, 1, 6'b000000, 6'b000000, 1);
    stp("mcs.t3", 0, 2'b00, 0, 5'd0, 0, 0, 6'b001111, 6'b010000, 1);
    stp("mcs.t4", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);

    // flush aborts a long multicycle on its third cycle
    stp("mcf.t0", 0, 2'b00, 1, 5'd8, 0, 0, 6'b001111, 6'b010000, 0);
    stp("mcf.t1", 0, 2'b00, 0, 5'd0, 0, 0, 6'b001111, 6'b010000, 1);
    stp("mcf.t2", 0, 2'b01, 0, 5'd0, 1, 1, 6'b000000, 6'b000000, 1);
    stp("mcf.t3", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);

    // flush overrides a same-cycle start
    stp("mcx.t0", 0, 2'b00, 1, 5'd4, 1, 0, 6'b000000, 6'b000000, 0);
    stp("mcx.t1", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);

    // reset in the middle of a multicycle
    stp("mcr.t0", 0, 2'b00, 1, 5'd8, 0, 0, 6'b001111, 6'b010000, 0);
    stp("mcr.t1", 0, 2'b00, 0, 5'd0, 0, 0, 6'b001111, 6'b010000, 1);
    stp("mcr.t2", 1, 2'b10, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 1);
    stp("mcr.t3", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    chk("mcr.stall_cnt", bus.stall_cnt, 32'd0);
    chk("mcr.timeout", 32'(bus.stall_timeout), 32'd0);

    // a gap restarts the run: 200 + 100 stalled cycles never time out
    for (int k = 0; k < 200; k++)
      stp("run200", 0, 2'b10, 0, 5'd0, 0, 0, 6'b001111, 6'b010000, 0);
    stp("gap", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    for (int k = 0; k < 100; k++)
      stp("run100", 0, 2'b10, 0, 5'd0, 0, 0, 6'b001111, 6'b010000, 0);
    stp("gap2", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    chk("gap.timeout", 32'(bus.stall_timeout), 32'd0);
    chk("gap.stall_cnt", bus.stall_cnt, 32'd300);

    // 300 continuous stalled cycles trip the watchdog after the 255th
    stp("rst2", 1, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    for (int k = 0; k < 300; k++) begin
      stp("run300", 0, 2'b10, 0, 5'd0, 0, 0, 6'b001111, 6'b010000, 0);
      if (k == 254) chk("tmo.before", 32'(bus.stall_timeout), 32'd0);
      if (k == 255) chk("tmo.after", 32'(bus.stall_timeout), 32'd1);
    end
    stp("tmo.drop", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    chk("tmo.sticky", 32'(bus.stall_timeout), 32'd1);
    chk("tmo.stall_cnt", bus.stall_cnt, 32'd300);
    stp("tmo.idle", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    chk("tmo.sticky2", 32'(bus.stall_timeout), 32'd1);
    stp("rst3", 1, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    stp("post", 0, 2'b00, 0, 5'd0, 0, 0, 6'b000000, 6'b000000, 0);
    chk("post.timeout", 32'(bus.stall_timeout), 32'd0);
    chk("post.stall_cnt", bus.stall_cnt, 32'd0);
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter NSTAGE, default 6, number of pipeline stages; stall bit 0 is the fetch stage (youngest).
REQ-002 Parameter NREQ, default 2, number of level-sensitive stall requesters.
REQ-003 Parameter REQ_DEPTH, default {8'd3, 8'd1}, packed NREQ×8 vector; field i gives the deepest stage that requester i freezes.
REQ-004 Parameter MC_DEPTH, default 3, deepest stage frozen by a multicycle operation.
REQ-005 Parameter CNTW, default 5, width of the multicycle length field.
REQ-006 Parameter TMOUT, default 255, continuous-stall limit in cycles.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 req  in  NREQ  level stall requests; bit i is requester i.
REQ-010 mc_start  in  1  one-cycle pulse that starts a multicycle operation.
REQ-011 mc_cycles  in  CNTW  length of the multicycle stall in cycles; sampled with mc_start.
REQ-012 flush  in  1  pipeline flush; aborts any multicycle stall.
REQ-013 stop_stall  in  1  global override that forces stall to zero.
REQ-014 stall  out  NSTAGE  per-stage freeze mask.
REQ-015 bubble  out  NSTAGE  per-stage NOP-insert mask.
REQ-016 mc_busy  out  1  high while the multicycle counter is nonzero.
REQ-017 stall_timeout  out  1  sticky watchdog flag.
REQ-018 stall_cnt  out  32  saturating count of cycles with stall[0]=1.

Function
REQ-019 Requester i SHALL contribute mask bits [REQ_DEPTH_i:0]; stall SHALL be the OR of all active contributions, combinational from req with zero latency.
REQ-020 The multicycle contribution SHALL be bits [MC_DEPTH:0], asserted when (mc_start & mc_cycles≠0) or mc_cnt≠0.
REQ-021 An accepted mc_start at cycle t SHALL stall cycles t through t+mc_cycles−1 inclusive: mc_cnt loads mc_cycles−1, then decrements to 0.
REQ-022 An mc_start with mc_cycles=0 SHALL produce no stall and SHALL leave mc_cnt unchanged.
REQ-023 An mc_start while mc_cnt≠0 SHALL be ignored.
REQ-024 mc_busy SHALL equal (mc_cnt≠0).
REQ-025 flush SHALL clear mc_cnt at the next edge, override a same-cycle mc_start, and force stall=0 and bubble=0 in its own cycle.
REQ-026 stop_stall SHALL force stall=0 and bubble=0 combinationally; mc_cnt SHALL still decrement while stop_stall is high.
REQ-027 flush SHALL take precedence over stop_stall, and stop_stall over all requests.
REQ-028 bubble[k] SHALL equal stall[k−1] & ~stall[k] for k≥1; bubble[0] SHALL be 0.
REQ-029 A run counter SHALL increment each cycle stall[0]=1 and clear when stall[0]=0; reaching TMOUT SHALL set stall_timeout, which stays set until rst.
REQ-030 The run counter SHALL saturate at TMOUT.
REQ-031 stall_cnt SHALL increment each cycle stall[0]=1 and saturate at 0xFFFF_FFFF.
REQ-032 Any REQ_DEPTH or MC_DEPTH value ≥ NSTAGE SHALL be clamped to NSTAGE−1.

Reset
REQ-033 With rst=1 at an edge, mc_cnt, the run counter, stall_timeout and stall_cnt SHALL all go to 0.
REQ-034 While rst=1, stall and bubble SHALL be 0 regardless of other inputs.
REQ-035 Reset asserted during a multicycle stall SHALL abort it; the first cycle after reset SHALL have mc_busy=0.

Structure
REQ-036 The reset-level define SHALL live in the shared defines include; default depths and TMOUT SHALL be defined there as named constants.
REQ-037 One sub-module, stall_mc_counter (load, decrement, clear, busy), SHALL be instantiated once.

Verification
REQ-038 req=2'b01 for one cycle -> stall=6'b000011, bubble=6'b000100 in that same cycle.
REQ-039 req=2'b11 -> stall=6'b001111; adding stop_stall=1 -> stall=0, bubble=0.
REQ-040 mc_start with mc_cycles=3 at cycle 10 -> stall=6'b001111 at cycles 10–12, 0 at 13; mc_busy high at 11–12; a second mc_start at 11 is ignored.
REQ-041 mc_cycles=8 started, flush at the third cycle -> stall=0 in the flush cycle, mc_busy=0 the following cycle.
REQ-042 req[1] held for 300 cycles with TMOUT=255 -> stall_timeout rises after the 255th stalled cycle, stays high after req drops, clears only on rst; stall_cnt=300.
REQ-043 rst asserted mid multicycle stall -> next cycle mc_busy=0, stall=0, stall_cnt=0, stall_timeout=0.
